reg_bank: RTL and testbench

//  Parametrised general-purpose register file: NREG x DATA_W storage, one primary write port, three

---
 rtl/cpu_pkg.sv | 19 +
 rtl/reg_scoreboard.sv | 90 +++++++++
 rtl/reg_bank.sv | 121 ++++++++++++
 tb/tb_reg_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                         |
// | Purpose  : Shared datapath sizing defaults and word/index typedefs used by |
// |            the register bank and its scoreboard.                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int C_DATA_W = 16;
  localparam int C_NREG   = 16;
  localparam int C_SEL_W  = 4;

  typedef logic [C_SEL_W-1:0]  reg_idx_t;
  typedef logic [C_DATA_W-1:0] word_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_scoreboard                                                  |
// | Purpose  : Busy-bit tracker for multi-cycle results. Grants locks on idle  |
// |            registers, clears busy on write-back and flags write-backs that |
// |            land on a register nobody locked.                               |
// | Ports    : clk, rst          clock / synchronous active-high reset         |
// |            dest_reg,sour_reg  lookup indices -> dr_busy, sr_busy           |
// |            lock_req,lock_reg  lock request -> lock_grant                   |
// |            ld_xfer, ld_reg    accepted write-back -> ld_err (next cycle)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG    = C_NREG,
  parameter int SEL_W   = C_SEL_W,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] dest_reg,
  input  logic [SEL_W-1:0] sour_reg,
  input  logic             lock_req,
  input  logic [SEL_W-1:0] lock_reg,
  input  logic             ld_xfer,
  input  logic [SEL_W-1:0] ld_reg,
  output logic             dr_busy,
  output logic             sr_busy,
  output logic             lock_grant,
  output logic             ld_err
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            ld_err_q;
  logic            ld_err_d;

  // Scanning every entry keeps indices >= NREG harmless: they match nothing
  // and so report "not busy" / "not present".
  function automatic logic f_busy(input logic [NREG-1:0] vec,
                                  input logic [SEL_W-1:0] idx);
    f_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == SEL_W'(i)) f_busy = vec[i];
    end
  endfunction

  function automatic logic f_present(input logic [SEL_W-1:0] idx);
    f_present = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == SEL_W'(i)) f_present = 1'b1;
    end
  endfunction

  assign dr_busy    = f_busy(busy_q, dest_reg);
  assign sr_busy    = f_busy(busy_q, sour_reg);
  assign lock_grant = lock_req & f_present(lock_reg) & ~f_busy(busy_q, lock_reg);
  assign ld_err     = ld_err_q;

  always_comb begin
    busy_d = busy_q;
    // Clear first, then set: a grant can only coincide with a write-back to
    // the same register if that write-back is stray, and the fresh lock
    // must survive it.
    for (int i = 0; i < NREG; i++) begin
      if (ld_xfer && ld_reg == SEL_W'(i))      busy_d[i] = 1'b0;
      if (lock_grant && lock_reg == SEL_W'(i)) busy_d[i] = 1'b1;
    end
    // A hardwired-zero r0 is always ready, so locking it is a no-op.
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    ld_err_d = ld_xfer & f_present(ld_reg) & ~f_busy(busy_q, ld_reg);
    if (ZERO_R0 != 0 && ld_reg == '0) ld_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      ld_err_q <= ld_err_d;
    end
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : reg_bank                                                        |
// | Purpose  : NREG x DATA_W general-purpose register file with one primary    |
// |            write port, three combinational read ports, a busy scoreboard   |
// |            and a valid/ready write-back port for multi-cycle results.      |
// | Ports    : clk, rst                 clock / sync active-high reset         |
// |            we,dest_reg,wdata        primary write; dest_reg also reads dr  |
// |            sour_reg, reg_sel        read indices for sr, reg_out           |
// |            dr, sr, reg_out          read data                              |
// |            en_reg                   one-hot of dest_reg while we=1         |
// |            dr_busy, sr_busy         busy bits of dest_reg / sour_reg       |
// |            lock_req,lock_reg,       lock a register for a pending result   |
// |            lock_grant                                                      |
// |            ld_valid,ld_reg,ld_data, write-back handshake                   |
// |            ld_ready, ld_err         stray write-back pulse                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module reg_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W  = C_DATA_W,
  parameter int NREG    = C_NREG,
  parameter int SEL_W   = C_SEL_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [SEL_W-1:0]  dest_reg,
  input  logic [DATA_W-1:0] wdata,
  input  logic [SEL_W-1:0]  sour_reg,
  input  logic [SEL_W-1:0]  reg_sel,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] sr,
  output logic [DATA_W-1:0] reg_out,
  output logic [NREG-1:0]   en_reg,
  output logic              dr_busy,
  output logic              sr_busy,
  input  logic              lock_req,
  input  logic [SEL_W-1:0]  lock_reg,
  output logic              lock_grant,
  input  logic              ld_valid,
  input  logic [SEL_W-1:0]  ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_err
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              w_ld_xfer;

  // The primary port always wins, so at most one write lands per cycle.
  assign ld_ready  = ~we;
  assign w_ld_xfer = ld_valid & ld_ready;

  // Indices >= NREG match no entry and read as zero. With bypass enabled a
  // write committing at the next edge is forwarded; r0 is never forwarded
  // when hardwired to zero.
  function automatic logic [DATA_W-1:0] f_read(input logic [SEL_W-1:0] idx);
    f_read = '0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == SEL_W'(i)) begin
        f_read = regs_q[i];
        if (BYPASS != 0 && !(ZERO_R0 != 0 && i == 0)) begin
          if (we && dest_reg == idx)             f_read = wdata;
          else if (w_ld_xfer && ld_reg == idx)   f_read = ld_data;
        end
      end
    end
  endfunction

  always_comb dr      = f_read(dest_reg);
  always_comb sr      = f_read(sour_reg);
  always_comb reg_out = f_read(reg_sel);

  for (genvar g = 0; g < NREG; g++) begin : g_en
    assign en_reg[g] = we & (dest_reg == SEL_W'(g));
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (!(ZERO_R0 != 0 && i == 0)) begin
        if (we && dest_reg == SEL_W'(i))            regs_d[i] = wdata;
        else if (w_ld_xfer && ld_reg == SEL_W'(i))  regs_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  reg_scoreboard #(
    .NREG    (NREG),
    .SEL_W   (SEL_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .dest_reg   (dest_reg),
    .sour_reg   (sour_reg),
    .lock_req   (lock_req),
    .lock_reg   (lock_reg),
    .ld_xfer    (w_ld_xfer),
    .ld_reg     (ld_reg),
    .dr_busy    (dr_busy),
    .sr_busy    (sr_busy),
    .lock_grant (lock_grant),
    .ld_err     (ld_err)
  );

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_reg_bank                                                     |
// | Purpose  : Directed self-checking bench for reg_bank (default sizing,      |
// |            bypass on, r0 writable). Inputs change 1 ns after the rising    |
// |            edge; outputs are sampled a further 1 ns later.                 |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_reg_bank;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  dest_reg;
  logic [15:0] wdata;
  logic [3:0]  sour_reg;
  logic [3:0]  reg_sel;
  logic [15:0] dr;
  logic [15:0] sr;
  logic [15:0] reg_out;
  logic [15:0] en_reg;
  logic        dr_busy;
  logic        sr_busy;
  logic        lock_req;
  logic [3:0]  lock_reg;
  logic        lock_grant;
  logic        ld_valid;
  logic [3:0]  ld_reg;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_bank #(
    .DATA_W  (16),
    .NREG    (16),
    .SEL_W   (4),
    .BYPASS  (1),
    .ZERO_R0 (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .dest_reg   (dest_reg),
    .wdata      (wdata),
    .sour_reg   (sour_reg),
    .reg_sel    (reg_sel),
    .dr         (dr),
    .sr         (sr),
    .reg_out    (reg_out),
    .en_reg     (en_reg),
    .dr_busy    (dr_busy),
    .sr_busy    (sr_busy),
    .lock_req   (lock_req),
    .lock_reg   (lock_reg),
    .lock_grant (lock_grant),
    .ld_valid   (ld_valid),
    .ld_reg     (ld_reg),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .ld_err     (ld_err)
  );

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; dest_reg = '0; wdata = '0; sour_reg = '0; reg_sel = '0;
    lock_req = 1'b0; lock_reg = '0; ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
    step();
    step();
    rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      reg_sel = 4'(s);
      #1;
      n_total++;
      if (reg_out !== 16'h0000)
        $display("FAIL reset_reg_out[%0d]: got %h expected 0000", s, reg_out);
      else n_pass++;
    end
    n_total++;
    if (dr_busy !== 1'b0 || sr_busy !== 1'b0)
      $display("FAIL reset_busy: got dr_busy=%b sr_busy=%b expected 0/0", dr_busy, sr_busy);
    else n_pass++;
    n_total++;
    if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b expected 1", ld_ready);
    else n_pass++;
    n_total++;
    if (ld_err !== 1'b0 || en_reg !== 16'h0000)
      $display("FAIL reset_err_en: got ld_err=%b en_reg=%h expected 0/0000", ld_err, en_reg);
    else n_pass++;
  endtask

  task automatic test_write_read();
    we = 1'b1; dest_reg = 4'd3; wdata = 16'hBEEF;
    #1;
    n_total++;
    if (dr !== 16'hBEEF) $display("FAIL wr_bypass_dr: got %h expected BEEF", dr);
    else n_pass++;
    n_total++;
    if (en_reg !== 16'h0008) $display("FAIL wr_en_reg: got %h expected 0008", en_reg);
    else n_pass++;
    n_total++;
    if (ld_ready !== 1'b0) $display("FAIL wr_ld_ready: got %b expected 0", ld_ready);
    else n_pass++;
    step();
    we = 1'b0; reg_sel = 4'd3; dest_reg = 4'd4;
    #1;
    n_total++;
    if (reg_out !== 16'hBEEF) $display("FAIL wr_reg_out: got %h expected BEEF", reg_out);
    else n_pass++;
    n_total++;
    if (en_reg !== 16'h0000 || dr !== 16'h0000)
      $display("FAIL wr_idle: got en_reg=%h dr(r4)=%h expected 0000/0000", en_reg, dr);
    else n_pass++;
  endtask

  task automatic test_lock_wb();
    lock_req = 1'b1; lock_reg = 4'd5;
    #1;
    n_total++;
    if (lock_grant !== 1'b1) $display("FAIL lock_first_grant: got %b expected 1", lock_grant);
    else n_pass++;
    step();
    sour_reg = 4'd5;
    #1;
    n_total++;
    if (sr_busy !== 1'b1) $display("FAIL lock_sr_busy: got %b expected 1", sr_busy);
    else n_pass++;
    n_total++;
    if (lock_grant !== 1'b0) $display("FAIL lock_second_grant: got %b expected 0", lock_grant);
    else n_pass++;
    step();
    lock_req = 1'b0;
    ld_valid = 1'b1; ld_reg = 4'd5; ld_data = 16'h1234;
    #1;
    n_total++;
    if (ld_ready !== 1'b1 || sr !== 16'h1234)
      $display("FAIL wb_same_cycle: got ld_ready=%b sr=%h expected 1/1234", ld_ready, sr);
    else n_pass++;
    step();
    ld_valid = 1'b0;
    #1;
    n_total++;
    if (sr_busy !== 1'b0 || sr !== 16'h1234)
      $display("FAIL wb_after: got sr_busy=%b sr=%h expected 0/1234", sr_busy, sr);
    else n_pass++;
    n_total++;
    if (ld_err !== 1'b0) $display("FAIL wb_ld_err: got %b expected 0", ld_err);
    else n_pass++;
  endtask

  task automatic test_conflict();
    lock_req = 1'b1; lock_reg = 4'd10;
    step();
    lock_req = 1'b0;
    we = 1'b1; dest_reg = 4'd9; wdata = 16'hAAAA;
    ld_valid = 1'b1; ld_reg = 4'd10; ld_data = 16'h5555;
    sour_reg = 4'd10;
    #1;
    n_total++;
    if (ld_ready !== 1'b0) $display("FAIL conflict_ld_ready: got %b expected 0", ld_ready);
    else n_pass++;
    n_total++;
    if (sr !== 16'h0000) $display("FAIL conflict_no_fwd: got %h expected 0000", sr);
    else n_pass++;
    step();
    we = 1'b0; reg_sel = 4'd9;
    #1;
    n_total++;
    if (reg_out !== 16'hAAAA) $display("FAIL conflict_primary: got %h expected AAAA", reg_out);
    else n_pass++;
    n_total++;
    if (sr_busy !== 1'b1 || ld_ready !== 1'b1)
      $display("FAIL conflict_held: got sr_busy=%b ld_ready=%b expected 1/1", sr_busy, ld_ready);
    else n_pass++;
    step();
    ld_valid = 1'b0;
    #1;
    n_total++;
    if (sr !== 16'h5555 || sr_busy !== 1'b0 || ld_err !== 1'b0)
      $display("FAIL conflict_ld_lands: got sr=%h sr_busy=%b ld_err=%b expected 5555/0/0",
               sr, sr_busy, ld_err);
    else n_pass++;
  endtask

  task automatic test_stray();
    ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'h00AA;
    step();
    ld_valid = 1'b0; reg_sel = 4'd7;
    #1;
    n_total++;
    if (reg_out !== 16'h00AA) $display("FAIL stray_data: got %h expected 00AA", reg_out);
    else n_pass++;
    n_total++;
    if (ld_err !== 1'b1) $display("FAIL stray_err_pulse: got %b expected 1", ld_err);
    else n_pass++;
    step();
    n_total++;
    if (ld_err !== 1'b0) $display("FAIL stray_err_clear: got %b expected 0", ld_err);
    else n_pass++;
  endtask

  task automatic test_lock_wb_overlap();
    lock_req = 1'b1; lock_reg = 4'd11;
    step();
    // Lock r12 while r11's result comes back: both take effect.
    lock_reg = 4'd12; ld_valid = 1'b1; ld_reg = 4'd11; ld_data = 16'hC0DE;
    #1;
    n_total++;
    if (lock_grant !== 1'b1) $display("FAIL overlap_diff_grant: got %b expected 1", lock_grant);
    else n_pass++;
    step();
    lock_req = 1'b0; ld_valid = 1'b0; dest_reg = 4'd11; sour_reg = 4'd12;
    #1;
    n_total++;
    if (dr_busy !== 1'b0 || sr_busy !== 1'b1 || ld_err !== 1'b0 || dr !== 16'hC0DE)
      $display("FAIL overlap_diff_state: got dr_busy=%b sr_busy=%b ld_err=%b dr=%h expected 0/1/0/C0DE",
               dr_busy, sr_busy, ld_err, dr);
    else n_pass++;
    // Lock r12 again while its result returns: denied, busy cleared.
    lock_req = 1'b1; lock_reg = 4'd12; ld_valid = 1'b1; ld_reg = 4'd12; ld_data = 16'h0BAD;
    #1;
    n_total++;
    if (lock_grant !== 1'b0) $display("FAIL overlap_same_grant: got %b expected 0", lock_grant);
    else n_pass++;
    step();
    lock_req = 1'b0; ld_valid = 1'b0;
    #1;
    n_total++;
    if (sr_busy !== 1'b0 || ld_err !== 1'b0 || sr !== 16'h0BAD)
      $display("FAIL overlap_same_state: got sr_busy=%b ld_err=%b sr=%h expected 0/0/0BAD",
               sr_busy, ld_err, sr);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    we = 1'b1; dest_reg = 4'd2; wdata = 16'h7777;
    step();
    we = 1'b0; lock_req = 1'b1; lock_reg = 4'd2;
    step();
    lock_req = 1'b0; sour_reg = 4'd2;
    #1;
    n_total++;
    if (sr_busy !== 1'b1 || sr !== 16'h7777)
      $display("FAIL midop_locked: got sr_busy=%b sr=%h expected 1/7777", sr_busy, sr);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_total++;
    if (sr_busy !== 1'b0 || sr !== 16'h0000)
      $display("FAIL midop_reset: got sr_busy=%b sr=%h expected 0/0000", sr_busy, sr);
    else n_pass++;
    ld_valid = 1'b1; ld_reg = 4'd2; ld_data = 16'h0042;
    step();
    ld_valid = 1'b0;
    #1;
    n_total++;
    if (ld_err !== 1'b1 || sr !== 16'h0042)
      $display("FAIL midop_late_wb: got ld_err=%b sr=%h expected 1/0042", ld_err, sr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_lock_wb();
    test_conflict();
    test_stray();
    test_lock_wb_overlap();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_bank
`default_nettype wire
